// File: rtl/hdb3_decoder.sv
// HDB3 line decoder.
// Turns the P/N mark lines back into NRZ data. Bipolar violations (V) are
// detected and their 000V / B00V substitutions removed. Illegal symbols and
// coding-rule errors are flagged and counted in a saturating counter.
//
// Output qualifier: there is no back-pressure. A bit on `data` counts as a
// decoded bit on any clk edge where `valid` is 1. `valid` stays 0 while the
// 4-deep delay line is still filling after reset.
module hdb3_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             P,
    input  logic             N,
    output logic             data,
    output logic             valid,
    output logic             bpv_err,
    output logic             code_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Polarity encoding: 1 = positive mark, 0 = negative mark.
    logic       last_pol;
    logic       last_v_pol;
    logic       v_seen;
    logic [3:0] dl;
    logic [2:0] zrun;
    logic [2:0] fill;

    logic             is_mark;
    logic             is_illegal;
    logic             is_v;
    logic             cur_bit;
    logic             vpol_err;
    logic             zrun_err;
    logic [3:0]       dl_next;
    logic [2:0]       zrun_next;
    logic [1:0]       n_events;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_next;

    // Classify the sampled symbol and work out the next decode/error state.
    always_comb begin
        is_mark    = P ^ N;
        is_illegal = P & N;
        is_v       = is_mark && (P == last_pol);
        cur_bit    = is_mark && !is_v;

        // A violation wipes the current bit and the three before it.
        // The oldest bit (dl[3]) has already left for `data` on this edge.
        if (is_v) begin
            dl_next = 4'b0000;
        end else begin
            dl_next = {dl[2:0], cur_bit};
        end

        // Two same-polarity violations in a row break the alternation rule.
        vpol_err = is_v && v_seen && (P == last_v_pol);

        // Run of spaces/illegal symbols. The counter saturates at 7, so the
        // 3->4 step fires only once per run.
        if (is_mark) begin
            zrun_next = 3'd0;
        end else if (zrun == 3'd7) begin
            zrun_next = 3'd7;
        end else begin
            zrun_next = zrun + 3'd1;
        end
        zrun_err = !is_mark && (zrun == 3'd3);

        // Both error pulses of this cycle feed the saturating counter.
        n_events = {1'b0, is_illegal} + {1'b0, (vpol_err | zrun_err)};
        cnt_sum  = {1'b0, err_cnt} + {{(CNT_W - 1){1'b0}}, n_events};
        if (cnt_sum[CNT_W]) begin
            cnt_next = CNT_MAX;
        end else begin
            cnt_next = cnt_sum[CNT_W-1:0];
        end
    end

    // Register all state and outputs; reset clears everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            data       <= 1'b0;
            valid      <= 1'b0;
            bpv_err    <= 1'b0;
            code_err   <= 1'b0;
            err_cnt    <= '0;
            dl         <= 4'b0000;
            last_pol   <= 1'b0;
            last_v_pol <= 1'b0;
            v_seen     <= 1'b0;
            zrun       <= 3'd0;
            fill       <= 3'd0;
        end else begin
            data     <= dl[3];
            dl       <= dl_next;
            bpv_err  <= is_illegal;
            code_err <= vpol_err | zrun_err;
            err_cnt  <= cnt_next;
            zrun     <= zrun_next;
            if (is_mark) begin
                last_pol <= P;
            end
            if (is_v) begin
                last_v_pol <= P;
                v_seen     <= 1'b1;
            end
            // fill stops at 4, so valid goes high on the 5th edge after reset.
            if (fill != 3'd4) begin
                fill <= fill + 3'd1;
            end
            valid <= (fill == 3'd4);
        end
    end

endmodule

// File: tb/tb_hdb3_decoder.sv
// Testbench for hdb3_decoder. A queue-based reference model decodes each
// symbol from the line rules and checks every output after every edge.
module tb_hdb3_decoder;

    logic       clk;
    logic       reset;
    logic       P;
    logic       N;
    logic       data;
    logic       valid;
    logic       bpv_err;
    logic       code_err;
    logic [7:0] err_cnt;

    int checks;
    int failures;

    // Reference model state
    logic [0:0] exp_q[$];   // decoded bit per symbol since reset release
    int  n_edge;            // non-reset edges since release
    bit  m_last_pol;        // 1 = positive
    bit  m_last_vpol;
    int  m_vcount;
    int  m_run;             // unsaturated zero-run length
    int  m_cnt;

    hdb3_decoder #(.CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .P        (P),
        .N        (N),
        .data     (data),
        .valid    (valid),
        .bpv_err  (bpv_err),
        .code_err (code_err),
        .err_cnt  (err_cnt)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0d want=%0d", tag, n_edge, obs, exp);
        end
    endtask

    // One reset edge with random line noise; everything must read zero.
    task automatic do_reset();
        reset = 1'b1;
        P = 1'($urandom);
        N = 1'($urandom);
        @(posedge clk);
        #1;
        exp_q.delete();
        n_edge      = 0;
        m_last_pol  = 1'b0;
        m_last_vpol = 1'b0;
        m_vcount    = 0;
        m_run       = 0;
        m_cnt       = 0;
        check("rst_data", 32'(data), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_bpv", 32'(bpv_err), 0);
        check("rst_code", 32'(code_err), 0);
        check("rst_cnt", 32'(err_cnt), 0);
        reset = 1'b0;
    endtask

    // Drive one symbol, advance the model, compare every output.
    task automatic step(input bit p, input bit n);
        bit mark, ill, pol, v, verr, zerr, e_data, e_bpv, e_code;
        P = p;
        N = n;
        @(posedge clk);
        #1;
        n_edge++;
        // The bit sampled at edge k appears on data at edge k+4.
        e_data = (n_edge >= 5) ? exp_q[n_edge - 5][0] : 1'b0;
        mark = p ^ n;
        ill  = p & n;
        pol  = p;
        v    = mark && (pol == m_last_pol);
        verr = 1'b0;
        if (mark) m_last_pol = pol;
        exp_q.push_back(1'(mark && !v));
        if (v) begin
            for (int i = exp_q.size() - 4; i < exp_q.size(); i++)
                if (i >= 0) exp_q[i] = 1'b0;
            verr = (m_vcount > 0) && (pol == m_last_vpol);
            m_last_vpol = pol;
            m_vcount++;
        end
        if (mark) m_run = 0;
        else      m_run++;
        zerr   = !mark && (m_run == 4);
        e_bpv  = ill;
        e_code = verr | zerr;
        m_cnt  = m_cnt + int'(e_bpv) + int'(e_code);
        if (m_cnt > 255) m_cnt = 255;
        check("data", 32'(data), 32'(e_data));
        check("valid", 32'(valid), (n_edge >= 5) ? 1 : 0);
        check("bpv_err", 32'(bpv_err), 32'(e_bpv));
        check("code_err", 32'(code_err), 32'(e_code));
        check("err_cnt", 32'(err_cnt), 32'(m_cnt));
    endtask

    // Mostly legal alternating marks with occasional spaces and illegal symbols.
    task automatic random_symbol();
        int r;
        r = $urandom_range(0, 15);
        if (r < 6)       step(1'b1, 1'b0);
        else if (r < 12) step(1'b0, 1'b1);
        else if (r < 15) step(1'b0, 1'b0);
        else             step(1'b1, 1'b1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        n_edge   = 0;
        reset    = 1'b1;
        P        = 1'b0;
        N        = 1'b0;
        @(posedge clk);
        do_reset();

        // Normal marks: data 1,0,1,1 from edge 5
        step(1, 0); step(0, 0); step(0, 1); step(1, 0);
        for (int i = 0; i < 4; i++) step(i[0], ~i[0]);

        // 000V substitution, first V
        do_reset();
        step(1, 0); step(0, 1); step(1, 0);
        step(0, 0); step(0, 0); step(0, 0); step(1, 0);
        for (int i = 0; i < 7; i++) step(i[0], ~i[0]);

        // B00V substitution; the following negative mark is then normal
        do_reset();
        step(1, 0); step(0, 0); step(0, 0); step(1, 0);
        step(0, 1); step(1, 0); step(0, 1); step(1, 0); step(0, 1);

        // Illegal symbol mid-stream
        do_reset();
        step(1, 0); step(0, 1); step(1, 1); step(1, 0); step(0, 1);
        for (int i = 0; i < 5; i++) step(i[0], ~i[0]);

        // Two positive V's in a row, then a 4-space run
        do_reset();
        step(1, 0); step(1, 0); step(0, 1); step(1, 0); step(1, 0);
        step(0, 0); step(0, 0); step(0, 0); step(0, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 6; i++) step(i[0], ~i[0]);

        // Randomized traffic with a mid-stream reset
        for (int i = 0; i < 400; i++) random_symbol();
        do_reset();
        for (int i = 0; i < 400; i++) random_symbol();

        // Saturation: 300 illegal symbols
        for (int i = 0; i < 300; i++) step(1, 1);
        for (int i = 0; i < 20; i++) random_symbol();
        check("err_cnt_sat", 32'(err_cnt), 255);

        // Reset mid-stream: outputs clear, nothing from before reset appears
        for (int i = 0; i < 3; i++) step(i[0], ~i[0]);
        do_reset();
        for (int i = 0; i < 40; i++) random_symbol();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hdb3_decoder.md
HDB3_DECODER -- requirements
Module: hdb3_decoder

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, setting the width of err_cnt.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port P, input, 1 bit: positive-mark line from the HDB3 line encoder, sampled once per clk.
REQ-005 The block SHALL have port N, input, 1 bit: negative-mark line from the HDB3 line encoder, sampled once per clk.
REQ-006 The block SHALL have port data, output, 1 bit: registered recovered NRZ bit.
REQ-007 The block SHALL have port valid, output, 1 bit: high when data carries a decoded bit, not pipeline fill.
REQ-008 The block SHALL have port bpv_err, output, 1 bit: one-cycle pulse for an illegal line symbol (P=N=1).
REQ-009 The block SHALL have port code_err, output, 1 bit: one-cycle pulse for an HDB3 coding-rule error.
REQ-010 The block SHALL have port err_cnt, output, CNT_W bits: saturating count of error events.

Function
REQ-011 Per cycle the block SHALL classify the sampled symbol: (P,N)=(1,0) positive mark; (0,1) negative mark; (0,0) space; (1,1) illegal.
REQ-012 An illegal symbol SHALL be decoded as 0, SHALL assert bpv_err the next cycle, and SHALL NOT change polarity state.
REQ-013 The block SHALL hold last_pol, the polarity of the most recent mark; reset value negative, so a first positive mark is normal.
REQ-014 A mark whose polarity equals last_pol SHALL be a violation (V); any other mark SHALL be a normal mark decoded as 1.
REQ-015 Every mark, normal or V, SHALL update last_pol to its own polarity.
REQ-016 A 4-stage delay line dl[3:0] SHALL hold decoded bits (dl[0] newest); each cycle data<=dl[3], then dl shifts by one and the current bit enters dl[0].
REQ-017 On a V, the current bit and the three preceding bits (old dl[2:0]) SHALL all be forced to 0, removing 000V and B00V substitutions; old dl[3] SHALL still be emitted on data.
REQ-018 Decode latency SHALL be exactly 4 clocks, from the edge sampling a symbol to the edge presenting its bit on data.
REQ-019 valid SHALL be 0 after reset and SHALL rise on the 5th non-reset edge after reset release, then stay 1, tracked by a saturating fill counter.
REQ-020 The block SHALL hold last_v_pol and v_seen; from the second V after reset onward, a V with polarity equal to last_v_pol SHALL pulse code_err the next cycle.
REQ-021 The block SHALL count consecutive space/illegal cycles in a 3-bit saturating counter cleared by any mark; reaching 4 SHALL pulse code_err once, not again until the next mark.
REQ-022 A violation-polarity error and a zero-run error in the same cycle SHALL produce a single code_err pulse.
REQ-023 err_cnt SHALL add the number of error events per cycle, so bpv_err and code_err together add 2 (or 1 if at max-1), and SHALL saturate at 2^CNT_W-1 without wrap.
REQ-024 All outputs SHALL be registered; no combinational path from P/N to any output.

Reset
REQ-025 While reset=1 at a clk edge, data, valid, bpv_err and code_err SHALL be set to 0, err_cnt to 0, and dl to 0000.
REQ-026 The same reset SHALL set last_pol negative, v_seen to 0, and the zero-run and fill counters to 0.
REQ-027 Reset asserted mid-stream SHALL discard all in-flight bits; no pre-reset bit SHALL appear on data after release.
REQ-028 P/N SHALL be ignored on reset cycles.

Verification
REQ-029 Normal marks: after reset drive (P,N)=(1,0),(0,0),(0,1),(1,0) -> data 1,0,1,1 on edges 5..8, valid=1 from edge 5, no errors, err_cnt=0.
REQ-030 000V substitution: drive (1,0),(0,1),(1,0),(0,0),(0,0),(0,0),(1,0) -> data 1,1,1,0,0,0,0, code_err=0 because it is the first V.
REQ-031 B00V substitution: after reset drive (1,0),(0,0),(0,0),(1,0) -> data 0,0,0,0 and last_pol positive.
REQ-032 Illegal symbol: drive (1,1) for one cycle mid-stream -> bpv_err high for exactly one cycle on the next edge, that data slot 0, err_cnt=1.
REQ-033 Coding errors: two successive positive V's -> code_err pulse on the second; 4 consecutive (0,0) cycles -> exactly one code_err pulse, err_cnt increments by 1 for each.
REQ-034 Saturation and reset: force 300 error events (CNT_W=8) -> err_cnt holds at 255; reset mid-stream -> all outputs 0 the next edge and valid low for 4 edges.
